// File: rtl/avalon_burst_slave_if.sv
// Avalon-MM bus bundle between the host master and avalon_burst_slave.
// Carries the command side (write/read/beginbursttransfer/burstcount/
// address/writedata), the completion side (readdata/readdatavalid/
// writeresponsevalid/response) and the waitrequest stall.
//   master modport: drives commands, observes completions and stall
//   slave  modport: observes commands, drives completions and stall
interface avalon_burst_slave_if #(
    parameter int ADDR_W  = 11,
    parameter int BURST_W = 10
);
    logic               write;
    logic               read;
    logic               beginbursttransfer;
    logic [BURST_W-1:0] burstcount;
    logic [ADDR_W-1:0]  address;
    logic [31:0]        writedata;
    logic [31:0]        readdata;
    logic               readdatavalid;
    logic               writeresponsevalid;
    logic [1:0]         response;
    logic               waitrequest;

    modport master (
        output write, read, beginbursttransfer, burstcount, address, writedata,
        input  readdata, readdatavalid, writeresponsevalid, response, waitrequest
    );

    modport slave (
        input  write, read, beginbursttransfer, burstcount, address, writedata,
        output readdata, readdatavalid, writeresponsevalid, response, waitrequest
    );
endinterface

// File: rtl/avalon_burst_slave.sv
// Avalon-MM slave front end for the neural-net accelerator.
// Accepts single-beat reads, single-beat writes and counted burst writes
// with address auto-increment, and turns each decoded write beat into a
// weight-memory or pixel-memory write strobe. Also holds a control
// register (start), a status register (busy/done), a 32-bit scratch
// register and a read window onto the core's result outputs.
// Ports:
//   clk, n_rst                 clock, asynchronous active-low reset
//   bus (slave modport)        Avalon-MM command/response/stall signals
//   weight_address, pixel_address, w_enable_weights, w_enable_pixels,
//   store_data                 memory write port (one strobe per beat)
//   output_address, result_output  result select and returned value
//   start_calc, done_calc      calculation core handshake
module avalon_burst_slave #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 11,
    parameter int BURST_W      = 10,
    parameter int WEIGHT_DEPTH = 784,
    parameter int PIXEL_BASE   = 'h400,
    parameter int PIXEL_DEPTH  = 784,
    parameter int RESULT_BASE  = 'h7E0,
    parameter int NUM_OUTPUTS  = 10,
    parameter int RESULT_W     = 17,
    parameter int CTRL_ADDR    = 'h7F0,
    parameter int STATUS_ADDR  = 'h7F1,
    parameter int SCRATCH_ADDR = 'h7F2,
    localparam int WA_W = $clog2(WEIGHT_DEPTH),
    localparam int PA_W = $clog2(PIXEL_DEPTH),
    localparam int OA_W = $clog2(NUM_OUTPUTS)
) (
    input  logic                clk,
    input  logic                n_rst,
    avalon_burst_slave_if.slave bus,
    output logic [WA_W-1:0]     weight_address,
    output logic [PA_W-1:0]     pixel_address,
    output logic                w_enable_weights,
    output logic                w_enable_pixels,
    output logic [DATA_W-1:0]   store_data,
    output logic [OA_W-1:0]     output_address,
    input  logic [RESULT_W-1:0] result_output,
    output logic                start_calc,
    input  logic                done_calc
);
    // One extra bit so base+k past the top of the address space stays
    // distinguishable (and therefore unmapped) instead of wrapping.
    localparam int EW = ((ADDR_W > BURST_W) ? ADDR_W : BURST_W) + 1;

    localparam logic [EW-1:0] WEIGHT_END = EW'(WEIGHT_DEPTH);
    localparam logic [EW-1:0] PIX_LO     = EW'(PIXEL_BASE);
    localparam logic [EW-1:0] PIX_END    = EW'(PIXEL_BASE + PIXEL_DEPTH);
    localparam logic [EW-1:0] RES_LO     = EW'(RESULT_BASE);
    localparam logic [EW-1:0] RES_END    = EW'(RESULT_BASE + NUM_OUTPUTS);
    localparam logic [EW-1:0] CTRL_E     = EW'(CTRL_ADDR);
    localparam logic [EW-1:0] STATUS_E   = EW'(STATUS_ADDR);
    localparam logic [EW-1:0] SCRATCH_E  = EW'(SCRATCH_ADDR);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, BURST, RESP} state_t;

    state_t             state_reg;
    logic               wait_rst_reg;
    logic [ADDR_W-1:0]  base_reg;
    logic [BURST_W-1:0] beat_reg;   // index of the beat expected next
    logic [BURST_W-1:0] last_reg;   // index of the final beat
    logic               err_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [31:0]        scratch_reg;
    logic [31:0]        readdata_reg;
    logic               readdatavalid_reg;
    logic               writeresponsevalid_reg;
    logic [1:0]         response_reg;
    logic [WA_W-1:0]    weight_address_reg;
    logic [PA_W-1:0]    pixel_address_reg;
    logic               w_enable_weights_reg;
    logic               w_enable_pixels_reg;
    logic [DATA_W-1:0]  store_data_reg;
    logic               start_calc_reg;

    logic [EW-1:0]      eff;
    logic               hit_weight, hit_pixel, hit_ctrl, hit_status;
    logic               hit_scratch, hit_result, beat_err;
    logic               stall, waitrequest_int;
    logic               beat_acc, read_acc, start_fire;
    logic [BURST_W-1:0] last_in;

    // Effective address of the current beat: the bus address in IDLE,
    // the latched base plus beat index while a burst is running.
    always_comb begin
        if (state_reg == BURST)
            eff = EW'(base_reg) + EW'(beat_reg);
        else
            eff = EW'(bus.address);
    end

    assign hit_weight  = (eff < WEIGHT_END);
    assign hit_pixel   = (eff >= PIX_LO) && (eff < PIX_END);
    assign hit_ctrl    = (eff == CTRL_E);
    assign hit_status  = (eff == STATUS_E);
    assign hit_scratch = (eff == SCRATCH_E);
    assign hit_result  = (eff >= RES_LO) && (eff < RES_END);
    assign beat_err    = !(hit_weight || hit_pixel || hit_scratch || hit_ctrl);

    // Memory writes are held off while the core is computing, since the
    // core owns the weight/pixel memories then. Register traffic flows.
    assign stall = busy_reg && (hit_weight || hit_pixel) &&
                   (((state_reg == IDLE) && bus.write) || (state_reg == BURST));
    assign waitrequest_int = wait_rst_reg || (state_reg == RESP) || stall;

    assign beat_acc   = bus.write && !waitrequest_int &&
                        ((state_reg == IDLE) || (state_reg == BURST));
    assign read_acc   = bus.read && !bus.write && !waitrequest_int &&
                        (state_reg == IDLE);
    assign start_fire = beat_acc && hit_ctrl && bus.writedata[0] && !busy_reg;

    // A burstcount of zero behaves as a single-beat burst.
    assign last_in = (bus.burstcount == '0) ? '0 : bus.burstcount - BURST_W'(1);

    // The result select is presented combinationally in the accept cycle so
    // the core's answer can be registered on the same edge.
    always_comb begin
        output_address = '0;
        if ((state_reg == IDLE) && bus.read && !bus.write && hit_result)
            output_address = OA_W'(eff - RES_LO);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg              <= IDLE;
            wait_rst_reg           <= 1'b1;
            base_reg               <= '0;
            beat_reg               <= '0;
            last_reg               <= '0;
            err_reg                <= 1'b0;
            busy_reg               <= 1'b0;
            done_reg               <= 1'b0;
            scratch_reg            <= '0;
            readdata_reg           <= '0;
            readdatavalid_reg      <= 1'b0;
            writeresponsevalid_reg <= 1'b0;
            response_reg           <= RESP_OKAY;
            weight_address_reg     <= '0;
            pixel_address_reg      <= '0;
            w_enable_weights_reg   <= 1'b0;
            w_enable_pixels_reg    <= 1'b0;
            store_data_reg         <= '0;
            start_calc_reg         <= 1'b0;
        end else begin
            wait_rst_reg           <= 1'b0;
            readdatavalid_reg      <= 1'b0;
            writeresponsevalid_reg <= 1'b0;
            response_reg           <= RESP_OKAY;
            readdata_reg           <= '0;
            w_enable_weights_reg   <= 1'b0;
            w_enable_pixels_reg    <= 1'b0;
            start_calc_reg         <= 1'b0;

            // A start write in the same cycle as done_calc takes priority.
            if (start_fire) begin
                busy_reg       <= 1'b1;
                done_reg       <= 1'b0;
                start_calc_reg <= 1'b1;
            end else if (done_calc) begin
                busy_reg <= 1'b0;
                done_reg <= 1'b1;
            end

            if (beat_acc) begin
                if (hit_weight) begin
                    w_enable_weights_reg <= 1'b1;
                    weight_address_reg   <= WA_W'(eff);
                    store_data_reg       <= bus.writedata[DATA_W-1:0];
                end
                if (hit_pixel) begin
                    w_enable_pixels_reg <= 1'b1;
                    pixel_address_reg   <= PA_W'(eff - PIX_LO);
                    store_data_reg      <= bus.writedata[DATA_W-1:0];
                end
                if (hit_scratch)
                    scratch_reg <= bus.writedata;
            end

            case (state_reg)
                IDLE: begin
                    if (beat_acc) begin
                        if (bus.beginbursttransfer) begin
                            base_reg <= bus.address;
                            last_reg <= last_in;
                            beat_reg <= BURST_W'(1);
                            err_reg  <= beat_err;
                            if (last_in == '0) begin
                                state_reg              <= RESP;
                                writeresponsevalid_reg <= 1'b1;
                                response_reg <= beat_err ? RESP_SLVERR : RESP_OKAY;
                            end else begin
                                state_reg <= BURST;
                            end
                        end else begin
                            writeresponsevalid_reg <= 1'b1;
                            response_reg <= beat_err ? RESP_SLVERR : RESP_OKAY;
                        end
                    end else if (read_acc) begin
                        readdatavalid_reg <= 1'b1;
                        if (hit_scratch)
                            readdata_reg <= scratch_reg;
                        else if (hit_status)
                            readdata_reg <= {30'b0, done_reg, busy_reg};
                        else if (hit_result)
                            readdata_reg <= {{(32-RESULT_W){result_output[RESULT_W-1]}},
                                             result_output};
                        else if (!hit_ctrl)
                            response_reg <= RESP_SLVERR;
                    end
                end
                BURST: begin
                    if (beat_acc) begin
                        err_reg <= err_reg || beat_err;
                        if (beat_reg == last_reg) begin
                            state_reg              <= RESP;
                            writeresponsevalid_reg <= 1'b1;
                            response_reg <= (err_reg || beat_err) ? RESP_SLVERR : RESP_OKAY;
                        end else begin
                            beat_reg <= beat_reg + BURST_W'(1);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.readdata           = readdata_reg;
    assign bus.readdatavalid      = readdatavalid_reg;
    assign bus.writeresponsevalid = writeresponsevalid_reg;
    assign bus.response           = response_reg;
    assign bus.waitrequest        = waitrequest_int;
    assign weight_address         = weight_address_reg;
    assign pixel_address          = pixel_address_reg;
    assign w_enable_weights       = w_enable_weights_reg;
    assign w_enable_pixels        = w_enable_pixels_reg;
    assign store_data             = store_data_reg;
    assign start_calc             = start_calc_reg;
endmodule

// File: tb/tb_avalon_burst_slave.sv
// Directed testbench for avalon_burst_slave: reset state, scratch access,
// a burst straddling the weight/unmapped boundary, a full pixel burst,
// start/busy/done handshake with a stalled memory write, result readback,
// zero burstcount, start/done collision and reset in the middle of a burst.
module tb_avalon_burst_slave;
    logic        tb_clk = 1'b0;
    logic        n_rst;
    logic [9:0]  weight_address;
    logic [9:0]  pixel_address;
    logic        w_enable_weights;
    logic        w_enable_pixels;
    logic [15:0] store_data;
    logic [3:0]  output_address;
    logic [16:0] result_output;
    logic        start_calc;
    logic        done_calc;

    int n_assert = 0;
    int n_fail   = 0;
    int good;

    avalon_burst_slave_if #(.ADDR_W(11), .BURST_W(10)) bus ();

    avalon_burst_slave dut (
        .clk              (tb_clk),
        .n_rst            (n_rst),
        .bus              (bus.slave),
        .weight_address   (weight_address),
        .pixel_address    (pixel_address),
        .w_enable_weights (w_enable_weights),
        .w_enable_pixels  (w_enable_pixels),
        .store_data       (store_data),
        .output_address   (output_address),
        .result_output    (result_output),
        .start_calc       (start_calc),
        .done_calc        (done_calc)
    );

    always #5 tb_clk = ~tb_clk;

    // Core model: output 3 carries a negative full-scale value, others 0x100+n.
    assign result_output = (output_address == 4'd3) ? 17'h1FFFF
                                                     : 17'h00100 + 17'(output_address);

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_rst = 1'b0;
        done_calc = 1'b0;
        bus.write = 1'b0;
        bus.read = 1'b0;
        bus.beginbursttransfer = 1'b0;
        bus.burstcount = '0;
        bus.address = '0;
        bus.writedata = '0;

        // Reset state
        repeat (3) @(posedge tb_clk);
        #1;
        chk("rst_waitrequest", bus.waitrequest, 1);
        chk("rst_rdv", bus.readdatavalid, 0);
        chk("rst_wrv", bus.writeresponsevalid, 0);
        chk("rst_readdata", bus.readdata, 0);
        chk("rst_response", bus.response, 0);
        chk("rst_wen_w", w_enable_weights, 0);
        chk("rst_wen_p", w_enable_pixels, 0);
        chk("rst_start", start_calc, 0);
        chk("rst_store", store_data, 0);
        chk("rst_outaddr", output_address, 0);
        n_rst = 1'b1;
        #1;
        chk("rel_wait_before_edge", bus.waitrequest, 1);
        tick();
        chk("rel_wait_cycle1", bus.waitrequest, 0);
        tick();
        chk("rel_wait_cycle2", bus.waitrequest, 0);
        $display("reset: done");

        // Scratch write followed back-to-back by a read
        bus.write = 1'b1; bus.address = 11'h7F2; bus.writedata = 32'h8;
        tick();
        bus.write = 1'b0; bus.read = 1'b1;
        chk("scr_wr_wrv", bus.writeresponsevalid, 1);
        chk("scr_wr_resp", bus.response, 0);
        tick();
        bus.read = 1'b0;
        chk("scr_rd_rdv", bus.readdatavalid, 1);
        chk("scr_rd_data", bus.readdata, 32'h8);
        chk("scr_rd_resp", bus.response, 0);
        tick();
        chk("scr_rd_rdv_oneshot", bus.readdatavalid, 0);
        $display("scratch: wrote 8, read %0h", 32'h8);

        // Burst at 0x30E x4: two weight beats then two unmapped beats
        bus.write = 1'b1; bus.beginbursttransfer = 1'b1; bus.burstcount = 10'd4;
        bus.address = 11'h30E; bus.writedata = 32'd1;
        tick();
        bus.beginbursttransfer = 1'b0; bus.address = '0; bus.writedata = 32'd2;
        chk("b4_beat0_wen", w_enable_weights, 1);
        chk("b4_beat0_addr", weight_address, 782);
        chk("b4_beat0_data", store_data, 1);
        tick();
        bus.writedata = 32'd3;
        chk("b4_beat1_wen", w_enable_weights, 1);
        chk("b4_beat1_addr", weight_address, 783);
        chk("b4_beat1_data", store_data, 2);
        chk("b4_beat1_no_wrv", bus.writeresponsevalid, 0);
        tick();
        bus.writedata = 32'd4;
        chk("b4_beat2_no_wen", {w_enable_weights, w_enable_pixels}, 0);
        tick();
        bus.write = 1'b0;
        chk("b4_beat3_no_wen", {w_enable_weights, w_enable_pixels}, 0);
        chk("b4_wrv", bus.writeresponsevalid, 1);
        chk("b4_resp", bus.response, 2'b10);
        #1;
        chk("b4_resp_wait", bus.waitrequest, 1);
        tick();
        chk("b4_wrv_oneshot", bus.writeresponsevalid, 0);
        $display("burst 0x30E x4: response 10");

        // Full pixel burst, 784 beats
        bus.write = 1'b1; bus.beginbursttransfer = 1'b1; bus.burstcount = 10'd784;
        bus.address = 11'h400; bus.writedata = 32'd0;
        good = 0;
        for (int k = 0; k < 784; k++) begin
            tick();
            bus.beginbursttransfer = 1'b0; bus.address = '0;
            bus.writedata = 32'(k + 1);
            if (w_enable_pixels === 1'b1 && w_enable_weights === 1'b0 &&
                pixel_address === 10'(k) && store_data === 16'(k) &&
                bus.writeresponsevalid === (k == 783))
                good++;
        end
        bus.write = 1'b0;
        chk("pix_burst_beats", good, 784);
        chk("pix_burst_wrv", bus.writeresponsevalid, 1);
        chk("pix_burst_resp", bus.response, 0);
        tick();
        $display("pixel burst: %0d beats in order", good);

        // Start calculation, read status, start while busy
        bus.write = 1'b1; bus.address = 11'h7F0; bus.writedata = 32'h1;
        tick();
        bus.write = 1'b0; bus.read = 1'b1; bus.address = 11'h7F1;
        chk("start_pulse", start_calc, 1);
        chk("start_wrv", bus.writeresponsevalid, 1);
        chk("start_resp", bus.response, 0);
        tick();
        bus.read = 1'b0;
        chk("start_pulse_oneshot", start_calc, 0);
        chk("status_busy", bus.readdata, 1);
        bus.write = 1'b1; bus.address = 11'h7F0; bus.writedata = 32'h1;
        tick();
        bus.write = 1'b0;
        chk("busy_start_nopulse", start_calc, 0);
        chk("busy_start_wrv", bus.writeresponsevalid, 1);
        chk("busy_start_resp", bus.response, 0);
        $display("start: status busy");

        // Pixel write stalls until done_calc
        bus.write = 1'b1; bus.address = 11'h405; bus.writedata = 32'h55;
        #1;
        chk("stall_wait", bus.waitrequest, 1);
        tick();
        tick();
        chk("stall_no_wen", w_enable_pixels, 0);
        chk("stall_no_wrv", bus.writeresponsevalid, 0);
        done_calc = 1'b1;
        tick();
        done_calc = 1'b0;
        #1;
        chk("stall_release", bus.waitrequest, 0);
        tick();
        bus.write = 1'b0; bus.read = 1'b1; bus.address = 11'h7F1;
        chk("stalled_wen", w_enable_pixels, 1);
        chk("stalled_addr", pixel_address, 5);
        chk("stalled_data", store_data, 16'h55);
        chk("stalled_wrv", bus.writeresponsevalid, 1);
        tick();
        bus.read = 1'b0;
        chk("status_done", bus.readdata, 2);
        $display("done: stalled pixel write completed");

        // Result window and unmapped read
        bus.read = 1'b1; bus.address = 11'h7E3;
        #1;
        chk("res_outaddr", output_address, 3);
        tick();
        bus.address = 11'h100;
        chk("res3_rdv", bus.readdatavalid, 1);
        chk("res3_data", bus.readdata, 32'hFFFFFFFF);
        chk("res3_resp", bus.response, 0);
        tick();
        bus.address = 11'h7E5;
        chk("unmapped_rd_data", bus.readdata, 0);
        chk("unmapped_rd_resp", bus.response, 2'b10);
        tick();
        bus.address = 11'h7F0;
        chk("res5_data", bus.readdata, 32'h105);
        tick();
        bus.read = 1'b0;
        chk("ctrl_rd_data", bus.readdata, 0);
        chk("ctrl_rd_resp", bus.response, 0);
        $display("results: read back");

        // burstcount 0 behaves as a single-beat burst
        bus.write = 1'b1; bus.beginbursttransfer = 1'b1; bus.burstcount = '0;
        bus.address = 11'h010; bus.writedata = 32'h7;
        tick();
        bus.write = 1'b0; bus.beginbursttransfer = 1'b0;
        chk("bc0_wen", w_enable_weights, 1);
        chk("bc0_addr", weight_address, 16);
        chk("bc0_data", store_data, 7);
        chk("bc0_wrv", bus.writeresponsevalid, 1);
        chk("bc0_resp", bus.response, 0);
        #1;
        chk("bc0_resp_wait", bus.waitrequest, 1);
        tick();
        chk("bc0_idle_wait", bus.waitrequest, 0);
        $display("burstcount 0: single beat");

        // Start write and done_calc in the same cycle: start wins
        bus.write = 1'b1; bus.address = 11'h7F0; bus.writedata = 32'h1;
        done_calc = 1'b1;
        tick();
        bus.write = 1'b0; done_calc = 1'b0;
        bus.read = 1'b1; bus.address = 11'h7F1;
        chk("collide_pulse", start_calc, 1);
        tick();
        bus.read = 1'b0;
        chk("collide_status", bus.readdata, 1);
        done_calc = 1'b1;
        tick();
        done_calc = 1'b0;
        $display("collision: start wins");

        // Reset in the middle of a burst
        bus.write = 1'b1; bus.beginbursttransfer = 1'b1; bus.burstcount = 10'd3;
        bus.address = 11'h200; bus.writedata = 32'hAA;
        tick();
        bus.beginbursttransfer = 1'b0;
        chk("midrst_beat0", w_enable_weights, 1);
        n_rst = 1'b0; bus.write = 1'b0;
        #1;
        chk("midrst_wen_cleared", w_enable_weights, 0);
        chk("midrst_wait", bus.waitrequest, 1);
        tick();
        n_rst = 1'b1;
        tick();
        chk("midrst_no_wrv1", bus.writeresponsevalid, 0);
        bus.read = 1'b1; bus.address = 11'h7F2;
        tick();
        bus.address = 11'h7F1;
        chk("midrst_no_wrv2", bus.writeresponsevalid, 0);
        chk("midrst_scratch", bus.readdata, 0);
        tick();
        bus.read = 1'b0;
        chk("midrst_status", bus.readdata, 0);
        $display("mid-burst reset: burst abandoned");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/avalon_burst_slave.md
Name: avalon_burst_slave

Overview:
Parametrised Avalon-MM slave front end for the neural-net accelerator. It replaces the single-beat host interface and adds counted burst writes with address auto-increment, per-transaction responses, a control/status register pair, a scratch register and a windowed result readback. Decoded beats drive the weight and pixel memory write ports, and the block handshakes start_calc/done_calc with the calculation core.

Parameters:
DATA_W, 16, stored word width (low bits of writedata)
ADDR_W, 11, Avalon word address width
BURST_W, 10, burstcount width
WEIGHT_DEPTH, 784, weight words at address 0..WEIGHT_DEPTH-1
PIXEL_BASE, 11'h400, first pixel address
PIXEL_DEPTH, 784, number of pixel words
RESULT_BASE, 11'h7E0, first result address
NUM_OUTPUTS, 10, result words (output_address width = $clog2(NUM_OUTPUTS))
RESULT_W, 17, result width, sign-extended to 32 on readdata
CTRL_ADDR, 11'h7F0, control register; write bit0=1 starts calculation
STATUS_ADDR, 11'h7F1, status register: bit0 busy, bit1 done
SCRATCH_ADDR, 11'h7F2, 32-bit read/write scratch register

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
write  in  1  Avalon write request
read  in  1  Avalon read request
beginbursttransfer  in  1  high with the first beat of a burst
burstcount  in  BURST_W  beats in burst; sampled with beginbursttransfer
address  in  ADDR_W  word address (burst base on first beat)
writedata  in  32  write data
readdata  out  32  read data, valid with readdatavalid
readdatavalid  out  1  one-cycle read completion strobe
writeresponsevalid  out  1  one-cycle write/burst completion strobe
response  out  2  00 OKAY, 10 SLAVEERROR; valid with either strobe
waitrequest  out  1  stall; a command is accepted when request high and waitrequest low
weight_address  out  $clog2(WEIGHT_DEPTH)  weight memory address
pixel_address  out  $clog2(PIXEL_DEPTH)  pixel memory address (offset from PIXEL_BASE)
w_enable_weights  out  1  weight write strobe
w_enable_pixels  out  1  pixel write strobe
store_data  out  DATA_W  data for either memory
output_address  out  $clog2(NUM_OUTPUTS)  result select to core
result_output  in  RESULT_W  combinational result for output_address
start_calc  out  1  one-cycle start pulse
done_calc  in  1  core completion (level or pulse)

Behaviour:
- Reset: all outputs 0, except waitrequest=1 while n_rst low; busy=0, done=0, scratch=0; FSM to IDLE, burst counters cleared. waitrequest deasserts in the first clk after release.
- FSM states: IDLE, BURST, RESP.
- IDLE, read accepted: burstcount is ignored (reads are single beat). readdatavalid=1 the next cycle, with readdata/response:
  - scratch: value, 00
  - status: {30'b0, done, busy}, 00
  - result window: output_address = address-RESULT_BASE driven in the accept cycle; the registered, sign-extended result_output is returned, 00
  - ctrl: 0, 00
  - anything else, including the weight/pixel regions: readdata 0, response 10
- IDLE, write accepted with beginbursttransfer=0: single beat. Decode as below. writeresponsevalid the next cycle.
- IDLE, write accepted with beginbursttransfer=1:
  - Latch base = address and count = burstcount (0 treated as 1).
  - Process beat 0 and go to BURST, or to RESP if count==1.
- BURST: each accepted write beat k targets base+k, decoded independently (a burst may cross from the weight to the pixel region). Address, read and beginbursttransfer are ignored. After the last beat, go to RESP.
- RESP: writeresponsevalid=1 for one cycle, then IDLE.
  - One response per burst: 10 if any beat was unmapped, else 00.
  - waitrequest=1 in RESP.
- Beat decode (effective address e):
  - weight region: the cycle after acceptance, w_enable_weights=1, weight_address=e, store_data=writedata[DATA_W-1:0]
  - pixel region: same, on the pixel port, with address e-PIXEL_BASE
  - scratch: full 32-bit write
  - ctrl with bit0=1: start_calc pulse the next cycle; busy=1, done=0
  - unmapped, or beyond 2^ADDR_W-1: beat discarded, error flagged, no address wrap-around
- Stall: waitrequest=1 while busy=1 and the current beat's effective address is in the weight or pixel region. Other accesses proceed.
- Status update: done_calc high sets done=1 and busy=0.
  - Same-cycle start write and done_calc: start wins (busy=1, done=0).
  - A start write while busy is accepted with 00 but produces no pulse.
- Throughput: one command per cycle in IDLE when not stalled. A new command may be accepted in the cycle its predecessor's strobe is high.
- Reset mid-burst: abandon the burst; no response or strobe is issued.

Test Plan:
- Reset -> all outputs 0; waitrequest 1 during reset, 0 two cycles after release.
- Write 32'h8 to 0x7F2, then read 0x7F2 -> writeresponsevalid with 00; then readdatavalid, readdata 32'h8, response 00.
- Burst at 0x30E with burstcount 4, data 1..4 -> w_enable_weights at addresses 782,783 with data 1,2, both beats written; beats 3,4 to 0x310,0x311 are unmapped and discarded; single writeresponsevalid with response 10.
- Burst at 0x400 with burstcount 784 -> 784 pixel strobes with pixel_address 0..783 in order; one response 00.
- Write 1 to 0x7F0 -> start_calc pulse; status reads 1; pixel write stalls; assert done_calc -> status reads 2 and the stalled write completes.
- Core drives result_output 17'h1FFFF for output_address 3 -> read 0x7E3 returns 32'hFFFFFFFF; read 0x100 returns 0 with response 10.
